// File: rtl/alu_result_tx_packer.sv
// Splits a full-width ALU result into NB_BYTE frames and hands them one at a
// time to a UART transmitter, handshaking on busy/done for every byte.
module alu_result_tx_packer #(
    parameter int NB_RESULT = 16,
    parameter int NB_BYTE   = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_RESULT-1:0] i_result,
    input  logic                 i_result_valid,
    output logic                 o_ready,
    output logic [NB_BYTE-1:0]   o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overrun
);

    localparam int NBYTES = NB_RESULT / NB_BYTE;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_FINISH    = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [NB_RESULT-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
    logic                 tx_start_q;
    logic                 done_q;
    logic                 overrun_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 byte_done;
    logic [NB_BYTE-1:0]   next_byte;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        byte_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_result_valid) begin
                    shift_d = i_result;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A transmitter fast enough to finish before busy is seen
                // must not stall the sequence.
                if (i_tx_done) begin
                    byte_done = 1'b1;
                end else if (i_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    byte_done = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (byte_done) begin
            if (cnt_q == LAST_CNT) begin
                state_d = ST_FINISH;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                shift_d = MSB_FIRST ? (shift_q << NB_BYTE) : (shift_q >> NB_BYTE);
                state_d = ST_SEND;
            end
        end
    end

    // Byte is taken from the next-state shift register so it is already
    // valid on the cycle the start pulse is presented.
    always_comb begin
        next_byte = MSB_FIRST ? shift_d[NB_RESULT-1 -: NB_BYTE] : shift_d[NB_BYTE-1:0];
        tx_data_d = (state_d == ST_SEND) ? next_byte : tx_data_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= (state_d == ST_SEND);
            done_q     <= (state_d == ST_FINISH);
            overrun_q  <= i_result_valid && (state_q != ST_IDLE);
            ready_q    <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign o_ready    = ready_q;
    assign o_busy     = busy_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_done     = done_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_result_tx_packer.sv
// Directed bench: one MSB-first and one LSB-first packer sharing the
// transmitter-side stimulus, checked against hand-computed byte sequences.
module tb_alu_result_tx_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] result = '0;
    logic        valid_m = 1'b0;
    logic        valid_l = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        sel = 1'b0;

    logic       m_ready, m_start, m_busy, m_done, m_ovr;
    logic [7:0] m_data;
    logic       l_ready, l_start, l_busy, l_done, l_ovr;
    logic [7:0] l_data;

    logic       ready_o, start_o, busy_o, done_o, ovr_o;
    logic [7:0] data_o;

    int checks = 0;
    int passes = 0;
    int n_start = 0;
    int n_done = 0;
    int n_ovr = 0;

    always #5 clk = ~clk;

    alu_result_tx_packer #(.NB_RESULT(16), .NB_BYTE(8), .MSB_FIRST(1'b1)) dut_m (
        .i_clk(clk), .i_reset(rst), .i_result(result), .i_result_valid(valid_m),
        .o_ready(m_ready), .o_tx_data(m_data), .o_tx_start(m_start),
        .i_tx_busy(tx_busy), .i_tx_done(tx_done),
        .o_busy(m_busy), .o_done(m_done), .o_overrun(m_ovr)
    );

    alu_result_tx_packer #(.NB_RESULT(16), .NB_BYTE(8), .MSB_FIRST(1'b0)) dut_l (
        .i_clk(clk), .i_reset(rst), .i_result(result), .i_result_valid(valid_l),
        .o_ready(l_ready), .o_tx_data(l_data), .o_tx_start(l_start),
        .i_tx_busy(tx_busy), .i_tx_done(tx_done),
        .o_busy(l_busy), .o_done(l_done), .o_overrun(l_ovr)
    );

    assign ready_o = sel ? l_ready : m_ready;
    assign start_o = sel ? l_start : m_start;
    assign busy_o  = sel ? l_busy  : m_busy;
    assign done_o  = sel ? l_done  : m_done;
    assign ovr_o   = sel ? l_ovr   : m_ovr;
    assign data_o  = sel ? l_data  : m_data;

    task automatic tick();
        @(posedge clk);
        #1;
        n_start += int'(start_o);
        n_done  += int'(done_o);
        n_ovr   += int'(ovr_o);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_counts();
        n_start = 0;
        n_done  = 0;
        n_ovr   = 0;
    endtask

    // Entered in the SEND cycle; leaves in the cycle after the done pulse.
    task automatic byte_ack(input int n, input logic [7:0] held);
        tx_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("data_hold", {8'h0, data_o}, {8'h0, held});
        end
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_ready", {15'h0, ready_o}, 16'h1);
        chk("rst_busy", {15'h0, busy_o}, 16'h0);
        chk("rst_start", {15'h0, start_o}, 16'h0);
        chk("rst_data", {8'h0, data_o}, 16'h0);
        chk("rst_done", {15'h0, done_o}, 16'h0);
        chk("rst_ovr", {15'h0, ovr_o}, 16'h0);
        rst = 1'b0;
        tick();

        // MSB first, A55A
        sel = 1'b0;
        clear_counts();
        result = 16'hA55A;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        chk("t1_start0", {15'h0, start_o}, 16'h1);
        chk("t1_byte0", {8'h0, data_o}, 16'h00A5);
        chk("t1_busy", {15'h0, busy_o}, 16'h1);
        chk("t1_ready", {15'h0, ready_o}, 16'h0);
        byte_ack(3, 8'hA5);
        chk("t1_start1", {15'h0, start_o}, 16'h1);
        chk("t1_byte1", {8'h0, data_o}, 16'h005A);
        byte_ack(3, 8'h5A);
        chk("t1_done", {15'h0, done_o}, 16'h1);
        chk("t1_ready_fin", {15'h0, ready_o}, 16'h0);
        tick();
        chk("t1_done_low", {15'h0, done_o}, 16'h0);
        chk("t1_ready_idle", {15'h0, ready_o}, 16'h1);
        chk("t1_busy_idle", {15'h0, busy_o}, 16'h0);
        tick();
        chk("t1_nstart", 16'(n_start), 16'd2);
        chk("t1_ndone", 16'(n_done), 16'd1);

        // LSB first, 1234
        sel = 1'b1;
        clear_counts();
        result = 16'h1234;
        valid_l = 1'b1;
        tick();
        valid_l = 1'b0;
        chk("t2_start0", {15'h0, start_o}, 16'h1);
        chk("t2_byte0", {8'h0, data_o}, 16'h0034);
        tx_busy = 1'b1;
        tick();
        chk("t2_hold_a", {8'h0, data_o}, 16'h0034);
        tick();
        chk("t2_hold_b", {8'h0, data_o}, 16'h0034);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t2_start1", {15'h0, start_o}, 16'h1);
        chk("t2_byte1", {8'h0, data_o}, 16'h0012);
        byte_ack(2, 8'h12);
        chk("t2_done", {15'h0, done_o}, 16'h1);
        tick();
        tick();
        chk("t2_nstart", 16'(n_start), 16'd2);
        chk("t2_ndone", 16'(n_done), 16'd1);

        // Overrun during WAIT_DONE of 00C3
        sel = 1'b0;
        clear_counts();
        result = 16'h00C3;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        chk("t3_byte0", {8'h0, data_o}, 16'h0000);
        tx_busy = 1'b1;
        tick();
        tick();
        result = 16'hFFFF;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        chk("t3_ovr", {15'h0, ovr_o}, 16'h1);
        tick();
        chk("t3_ovr_low", {15'h0, ovr_o}, 16'h0);
        chk("t3_hold", {8'h0, data_o}, 16'h0000);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t3_byte1", {8'h0, data_o}, 16'h00C3);
        byte_ack(2, 8'hC3);
        chk("t3_done", {15'h0, done_o}, 16'h1);
        repeat (4) tick();
        chk("t3_nstart", 16'(n_start), 16'd2);
        chk("t3_novr", 16'(n_ovr), 16'd1);
        chk("t3_ready", {15'h0, ready_o}, 16'h1);

        // Busy and done together right after the first start
        clear_counts();
        result = 16'hBEEF;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        chk("t4_byte0", {8'h0, data_o}, 16'h00BE);
        tick();
        tx_busy = 1'b1;
        tx_done = 1'b1;
        tick();
        tx_busy = 1'b0;
        tx_done = 1'b0;
        chk("t4_start1", {15'h0, start_o}, 16'h1);
        chk("t4_byte1", {8'h0, data_o}, 16'h00EF);
        byte_ack(2, 8'hEF);
        tick();
        tick();
        chk("t4_nstart", 16'(n_start), 16'd2);
        chk("t4_ndone", 16'(n_done), 16'd1);

        // Reset during second byte's WAIT_DONE
        result = 16'h5AA5;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        byte_ack(2, 8'h5A);
        chk("t5_byte1", {8'h0, data_o}, 16'h00A5);
        tx_busy = 1'b1;
        tick();
        tick();
        chk("t5_busy_pre", {15'h0, busy_o}, 16'h1);
        #2;
        rst = 1'b1;
        tx_busy = 1'b0;
        #1;
        chk("t5_async_data", {8'h0, data_o}, 16'h0000);
        chk("t5_async_busy", {15'h0, busy_o}, 16'h0);
        chk("t5_async_ready", {15'h0, ready_o}, 16'h1);
        chk("t5_async_start", {15'h0, start_o}, 16'h0);
        clear_counts();
        tick();
        rst = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        tick();
        chk("t5_nstart", 16'(n_start), 16'd0);
        chk("t5_ndone", 16'(n_done), 16'd0);
        chk("t5_ready", {15'h0, ready_o}, 16'h1);

        // Back-to-back: valid with o_done overruns, valid after o_done is taken
        clear_counts();
        result = 16'h0102;
        valid_m = 1'b1;
        tick();
        valid_m = 1'b0;
        chk("t6_byte0", {8'h0, data_o}, 16'h0001);
        byte_ack(2, 8'h01);
        chk("t6_byte1", {8'h0, data_o}, 16'h0002);
        byte_ack(2, 8'h02);
        chk("t6_done", {15'h0, done_o}, 16'h1);
        result = 16'h0304;
        valid_m = 1'b1;
        tick();
        chk("t6_ovr", {15'h0, ovr_o}, 16'h1);
        chk("t6_ready", {15'h0, ready_o}, 16'h1);
        tick();
        valid_m = 1'b0;
        chk("t6_start_b2b", {15'h0, start_o}, 16'h1);
        chk("t6_byte_b2b", {8'h0, data_o}, 16'h0003);
        byte_ack(2, 8'h03);
        chk("t6_byte_b2b1", {8'h0, data_o}, 16'h0004);
        byte_ack(2, 8'h04);
        tick();
        tick();
        chk("t6_nstart", 16'(n_start), 16'd4);
        chk("t6_ndone", 16'(n_done), 16'd2);
        chk("t6_novr", 16'(n_ovr), 16'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_tx_packer.md
Name: alu_result_tx_packer

Overview:
- TX-side counterpart of interface_uart_alu: takes a full-width ALU result and sends it over uart_transmitter as a sequence of bytes, so no result bits are dropped.
- Sits between ALU.o_result and uart_transmitter (i_data, i_tx_start, o_tx_transmiting, o_tx_done).
- Handshakes per byte with the transmitter and accepts one result at a time.

Parameters:
- NB_RESULT, 16, result width; must be an integer multiple of NB_BYTE.
- NB_BYTE, 8, UART payload width per frame.
- MSB_FIRST, 1, byte order: 1 = most significant byte sent first, 0 = least significant byte sent first.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_result  input  NB_RESULT  ALU result to transmit
- i_result_valid  input  1  single-cycle request to send i_result
- o_ready  output  1  high when a new result can be accepted
- o_tx_data  output  NB_BYTE  byte presented to uart_transmitter.i_data
- o_tx_start  output  1  single-cycle start pulse to uart_transmitter
- i_tx_busy  input  1  from uart_transmitter.o_tx_transmiting
- i_tx_done  input  1  from uart_transmitter.o_tx_done (single-cycle pulse)
- o_busy  output  1  high while a result is in flight
- o_done  output  1  single-cycle pulse after the last byte's i_tx_done
- o_overrun  output  1  single-cycle pulse when i_result_valid arrives while o_ready=0

Behaviour:
- Reset (async, active-high): state=IDLE, shift register=0, byte counter=0, o_tx_data=0, o_tx_start=0, o_done=0, o_overrun=0, o_busy=0, o_ready=1.
- NBYTES = NB_RESULT/NB_BYTE. Byte counter width is clog2(NBYTES), minimum 1.
- o_ready=1 only in IDLE. o_busy = !o_ready.
- All outputs are registered.
- IDLE:
  - If i_result_valid, latch i_result into the shift register, clear the counter, go to SEND.
- SEND (one cycle):
  - o_tx_data = current byte: the upper NB_BYTE bits of the shift register if MSB_FIRST, otherwise the lower bits.
  - o_tx_start=1 for exactly this cycle; next state WAIT_BUSY.
- Latency: i_result_valid sampled at edge N gives o_tx_start=1 during cycle N+1.
- o_tx_data holds its value from SEND until the matching i_tx_done is consumed; it never changes while i_tx_busy=1.
- WAIT_BUSY:
  - i_tx_busy=1 -> WAIT_DONE.
  - i_tx_done=1 (alone or together with busy) -> treated as byte complete; go straight to the byte-complete handling.
- WAIT_DONE:
  - Waits for i_tx_done=1; i_tx_busy is ignored here.
- Byte complete:
  - Counter == NBYTES-1 -> FINISH.
  - Otherwise increment the counter, shift the register by NB_BYTE toward the consumed end, go to SEND. The next o_tx_start is exactly 1 cycle after the i_tx_done edge.
- FINISH (one cycle): o_done=1, then IDLE. o_ready returns to 1 on the cycle after o_done.
- Overrun:
  - i_result_valid in any state other than IDLE pulses o_overrun the next cycle.
  - The request is discarded; the in-flight transfer is unaffected and no data is queued.
- Reset mid-transfer: immediate return to reset values; o_tx_start drops asynchronously. A partially sent result is abandoned and never resumed.
- i_tx_done while in IDLE, SEND or FINISH is ignored.

Test Plan:
- MSB_FIRST=1, i_result=16'hA55A pulsed once:
  - o_tx_start at N+1 with o_tx_data=8'hA5.
  - After the first i_tx_done, a second start with 8'h5A.
  - After the second i_tx_done, o_done pulses once and o_ready=1.
- MSB_FIRST=0, i_result=16'h1234: bytes 8'h34 then 8'h12; exactly two o_tx_start pulses; o_tx_data stable while i_tx_busy=1.
- i_result_valid=1 with 16'hFFFF during WAIT_DONE of 16'h00C3:
  - o_overrun pulses once.
  - Transmitted bytes remain 8'h00, 8'hC3.
  - No third start.
- Transmitter model asserts i_tx_busy and i_tx_done in the same cycle right after the first start: the FSM advances to byte 2 without hanging; total of 2 starts and 1 o_done.
- Assert i_reset during the second byte's WAIT_DONE:
  - All outputs go to reset values asynchronously.
  - A late i_tx_done after reset release produces no start and no o_done.
- Back-to-back: new i_result_valid on the cycle after o_done is accepted, with start at the following cycle. A valid pulse coincident with o_done yields o_overrun.
